// File: rtl/vector_mem_responder_pkg.sv
// vmem_pkg: shared types, sizes and mode encodings for the vector memory responder.
package vmem_pkg;
  localparam int LANES = 16;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH = 256;
  localparam int RAM_AW = $clog2(DEPTH);
  localparam int VEC_W = LANES * ELEM_W;
  localparam logic [3:0] MODE_H16 = 4'b0000;
  localparam logic [3:0] MODE_B8 = 4'b0001;
  typedef enum logic [1:0] {IDLE, XFER, RESP} vmem_state_t;
  typedef logic [LANES-1:0][ELEM_W-1:0] vec_t;
  function automatic logic [5:0] nbytes(input logic [3:0] mode);
    return (mode == MODE_B8) ? 6'd16 : 6'd32;
  endfunction
endpackage

// File: rtl/vector_mem_responder_ram.sv
// vmem_byte_ram: byte-wide storage with synchronous write and combinational read, never reset.
module vmem_byte_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/vector_mem_responder.sv
// vector_mem_responder: serialises one vector load/store into byte accesses and returns the gathered vector or an error.
module vector_mem_responder
  import vmem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              we_i,
  input  logic [3:0]        mode_i,
  input  logic [ADDR_W-1:0] a_i,
  input  logic [VEC_W-1:0]  wd_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [VEC_W-1:0]  rd_o,
  output logic              err_o
);
  localparam logic [ADDR_W:0] LIMIT = DEPTH[ADDR_W:0];
  vmem_state_t state_q, state_d;
  logic [5:0] cnt_q;
  logic we_q;
  logic [3:0] mode_q;
  logic [RAM_AW-1:0] a_q;
  logic [VEC_W-1:0] wd_q, rd_q;
  logic err_q;
  logic accept, bad, last, b8;
  logic [ADDR_W:0] end_addr;
  logic [RAM_AW-1:0] addr;
  logic [7:0] off, rdata;
  assign accept = state_q == IDLE && req_valid_i;
  // Range check is one bit wider than the address so a request can never wrap.
  assign end_addr = {1'b0, a_i} + {{(ADDR_W-5){1'b0}}, nbytes(mode_i)};
  assign bad = !(mode_i == MODE_H16 || mode_i == MODE_B8) || end_addr > LIMIT;
  assign b8 = mode_q == MODE_B8;
  assign last = cnt_q == nbytes(mode_q) - 6'd1;
  assign addr = a_q + RAM_AW'(cnt_q);
  assign off = b8 ? {cnt_q[3:0], 4'b0} : {cnt_q[4:0], 3'b0};
  vmem_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .we_i    (state_q == XFER && we_q),
    .addr_i  (addr),
    .wdata_i (wd_q[off +: 8]),
    .rdata_o (rdata)
  );
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = req_valid_i ? (bad ? RESP : XFER) : IDLE;
      XFER:    state_d = last ? RESP : XFER;
      RESP:    state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cnt_q  <= '0;
      we_q   <= 1'b0;
      mode_q <= '0;
      a_q    <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      we_q   <= we_i;
      mode_q <= mode_i;
      a_q    <= a_i[RAM_AW-1:0];
      wd_q   <= wd_i;
      rd_q   <= '0;
      err_q  <= bad;
    end else if (state_q == XFER) begin
      cnt_q <= cnt_q + 6'd1;
      if (!we_q && b8) rd_q[off +: 16] <= {8'h00, rdata};
      else if (!we_q) rd_q[off +: 8] <= rdata;
    end
  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign rd_o = rd_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_vector_mem_responder.sv
// tb_vector_mem_responder: scoreboard bench with a byte-array reference model of the storage.
module tb_vector_mem_responder;
  import vmem_pkg::*;
  typedef struct {vec_t rd; logic err; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst_n, req_valid, we, rsp_ready;
  logic [3:0] mode;
  logic [15:0] a;
  vec_t wd, rd;
  logic req_ready, rsp_valid, err;
  exp_t sbq[$];
  logic [7:0] mm [256];
  int errors = 0;
  int checks = 0;

  vector_mem_responder dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .we_i(we), .mode_i(mode), .a_i(a), .wd_i(wd), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rd_o(rd), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic predict(input logic w, input logic [3:0] m, input logic [15:0] ad, input vec_t d, output exp_t e);
    int nb;
    logic bad;
    nb = (m == 4'd1) ? 16 : 32;
    bad = !(m == 4'd0 || m == 4'd1) || (int'(ad) + nb > 256);
    e.err = bad;
    e.lat = bad ? 1 : nb + 1;
    e.rd = '0;
    if (!bad)
      for (int k = 0; k < nb; k++) begin
        if (m == 4'd0) begin
          if (w) mm[int'(ad) + k] = d[k/2][8*(k%2) +: 8];
          else e.rd[k/2][8*(k%2) +: 8] = mm[int'(ad) + k];
        end else begin
          if (w) mm[int'(ad) + k] = d[k][7:0];
          else e.rd[k] = {8'h00, mm[int'(ad) + k]};
        end
      end
  endtask

  task automatic send(input logic w, input logic [3:0] m, input logic [15:0] ad, input vec_t d);
    exp_t e;
    int n;
    predict(w, m, ad, d, e);
    sbq.push_back(e);
    we = w; mode = m; a = ad; wd = d;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got=%b exp=1", req_ready);
    end
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic get_rsp(output vec_t r, output logic e, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!rsp_valid && l < 200);
    r = rd;
    e = err;
    if (rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({req_ready, rsp_valid, err} !== 3'b100 || rd !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy/vld/err=%b rd=%h exp=100 rd=0", {req_ready, rsp_valid, err}, rd);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_h16;
    vec_t d, r;
    logic e;
    int l;
    exp_t x;
    d[0] = 16'h000F;
    for (int i = 1; i < 16; i++) d[i] = (i <= 4) ? 16'h0001 : (i == 5) ? 16'h0003 : 16'h0002;
    send(1'b1, 4'd0, 16'd0, d);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (l !== 33 || l !== x.lat || e !== 1'b0) begin
      errors++;
      $display("FAIL h16_store lat=%0d err=%b exp lat=33 err=0", l, e);
    end
    send(1'b0, 4'd0, 16'd0, '0);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (r !== x.rd || r !== d || e !== 1'b0) begin
      errors++;
      $display("FAIL h16_load rd=%h exp=%h err=%b", r, d, e);
    end
    checks++;
    if (r[0][7:0] !== 8'h0F || r[0][15:8] !== 8'h00) begin
      errors++;
      $display("FAIL h16_bytes01 got=%h exp=000f", r[0]);
    end
  endtask

  task automatic test_b8;
    vec_t d, r;
    logic e;
    int l;
    exp_t x;
    for (int i = 0; i < 16; i++) d[i] = 16'h6100 + 16'(i);
    send(1'b1, 4'd0, 16'd32, d);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    for (int i = 0; i < 16; i++) d[i] = 16'h00A0 + 16'(i);
    d[0] = 16'h1202;
    d[1] = 16'h0007;
    send(1'b1, 4'd1, 16'd8, d);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (l !== 17 || e !== 1'b0 || r !== '0) begin
      errors++;
      $display("FAIL b8_store lat=%0d err=%b rd=%h exp lat=17 err=0 rd=0", l, e, r);
    end
    send(1'b0, 4'd1, 16'd8, '0);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (r !== x.rd || r[0] !== 16'h0002 || r[1] !== 16'h0007 || l !== 17) begin
      errors++;
      $display("FAIL b8_load rd=%h exp=%h lat=%0d", r, x.rd, l);
    end
    send(1'b0, 4'd0, 16'd8, '0);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (r !== x.rd || r[0] !== 16'h0702) begin
      errors++;
      $display("FAIL b8_h16_load rd=%h exp=%h", r, x.rd);
    end
  endtask

  task automatic test_errors;
    vec_t d, r;
    logic e;
    int l;
    exp_t x;
    for (int i = 0; i < 16; i++) d[i] = 16'h3C00 + 16'(i);
    send(1'b1, 4'd0, 16'd224, d);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (e !== 1'b0 || l !== 33) begin
      errors++;
      $display("FAIL range_224 err=%b lat=%0d exp err=0 lat=33", e, l);
    end
    send(1'b1, 4'd0, 16'd225, {16{16'hFFFF}});
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (e !== 1'b1 || l !== 1 || x.err !== 1'b1 || r !== '0) begin
      errors++;
      $display("FAIL range_225 err=%b lat=%0d rd=%h exp err=1 lat=1 rd=0", e, l, r);
    end
    send(1'b0, 4'd0, 16'd224, '0);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (r !== x.rd || r !== d) begin
      errors++;
      $display("FAIL range_untouched rd=%h exp=%h", r, d);
    end
    send(1'b0, 4'b0100, 16'd0, '0);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (e !== 1'b1 || l !== 1) begin
      errors++;
      $display("FAIL mode_reserved err=%b lat=%0d exp err=1 lat=1", e, l);
    end
  endtask

  task automatic test_stall;
    vec_t r;
    logic e;
    int l;
    exp_t x;
    rsp_ready = 1'b0;
    send(1'b0, 4'd1, 16'd8, '0);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (r !== x.rd || e !== 1'b0 || l !== 17) begin
      errors++;
      $display("FAIL stall_first rd=%h exp=%h lat=%0d", r, x.rd, l);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        we = 1'b1; mode = 4'd0; a = 16'd100; req_valid = 1'b1;
      end else req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rd !== r || err !== e || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d vld=%b rdy=%b err=%b rd=%h exp vld=1 rdy=0 rd=%h", i, rsp_valid, req_ready, err, rd, r);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release rdy=%b vld=%b exp rdy=1 vld=0", req_ready, rsp_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_pulse_ignored vld=%b rdy=%b exp vld=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_xfer;
    vec_t p, q, r;
    logic e;
    int l;
    exp_t x;
    logic [7:0] sv [32];
    for (int i = 0; i < 16; i++) begin
      p[i] = 16'h5500 + 16'(i);
      q[i] = 16'hC300 + 16'(i);
    end
    send(1'b1, 4'd0, 16'd64, p);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    for (int k = 0; k < 32; k++) sv[k] = mm[64 + k];
    send(1'b1, 4'd0, 16'd64, q);
    x = sbq.pop_back();
    for (int k = 5; k < 32; k++) mm[64 + k] = sv[k];
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort vld=%b rdy=%b exp vld=0 rdy=1", rsp_valid, req_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    send(1'b0, 4'd0, 16'd64, '0);
    x = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (r !== x.rd || r[1] !== 16'hC301 || r[2] !== 16'h5502 || r[3] !== 16'h5503) begin
      errors++;
      $display("FAIL reset_partial rd=%h exp=%h", r, x.rd);
    end
  endtask

  task automatic test_back_to_back;
    vec_t r, r1;
    logic e;
    int l, hs, acc;
    exp_t x1, x2;
    rsp_ready = 1'b1;
    we = 1'b0; mode = 4'd1; a = 16'd8; wd = '0;
    predict(1'b0, 4'd1, 16'd8, '0, x1);
    sbq.push_back(x1);
    predict(1'b0, 4'd1, 16'd8, '0, x2);
    sbq.push_back(x2);
    hs = -1;
    acc = -1;
    r1 = '0;
    req_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (hs < 0 && rsp_valid && rsp_ready) begin
        hs = n;
        r1 = rd;
      end else if (hs >= 0 && req_ready && req_valid) begin
        acc = n;
        break;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    x1 = sbq.pop_front();
    checks++;
    if (hs < 0 || acc - hs !== 1 || r1 !== x1.rd) begin
      errors++;
      $display("FAIL b2b_gap hs=%0d acc=%0d rd=%h exp gap=1 rd=%h", hs, acc, r1, x1.rd);
    end
    x2 = sbq.pop_front();
    get_rsp(r, e, l);
    checks++;
    if (r !== x2.rd || l !== 17 || e !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second rd=%h exp=%h lat=%0d", r, x2.rd, l);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    we = 1'b0;
    mode = 4'd0;
    a = '0;
    wd = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_h16();
    test_b8();
    test_errors();
    test_stall();
    test_reset_mid_xfer();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
